aes_encipher_core: RTL and testbench
====================================

# aes_encipher_core

Iterative AES-128 encryption datapath: one 128-bit block per operation, computing all ten rounds in place from a single 128-bit cipher key with on-the-fly key expansion. The S-box is external: the core drives a 32-bit word out on `sboxw` and reads the combinational substitution back on `new_sboxw`, so one S-box instance can be shared. The block sits under the AES top level, beside the decipher core, which uses the same S-box port shape with `aes_inv_sbox`.

## Interface
- No parameters (AES-128 only; Nk=4, Nr=10 fixed).
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `init` in 1 — start pulse; sampled only in IDLE.
- `key` in 128 — cipher key; bits 127:120 = key byte 0.
- `plaintext` in 128 — input block; bits 127:120 = state byte 0; column-major FIPS-197 order.
- `ciphertext` out 128 — result register, same byte order.
- `sboxw` out 32 — word to substitute; byte-wise forward S-box expected.
- `new_sboxw` in 32 — S-box result, combinational from `sboxw`, same cycle.
- `ready` out 1 — high when idle and the result is valid.

## Operation
- FSM states: IDLE, INIT, KEYGEN, SUB, MAIN. Round counter is 4 bits, range 1..10.
- **IDLE**
  - `ready`=1, `sboxw`=0.
  - When `init`=1: capture `key` and `plaintext`, go to INIT.
- **INIT**
  - state ← plaintext ^ key; round key ← key; round ← 1.
- **KEYGEN**
  - Drive `sboxw` = RotWord(w3) of the current round key.
  - Next round key: w0' = w0 ^ new_sboxw ^ {Rcon[round],24'h0}; wi' = wi ^ w(i-1)' for i=1..3.
  - Rcon = 01,02,04,08,10,20,40,80,1b,36.
- **SUB**
  - 4 cycles, index 0..3. Drive `sboxw` = state word[index], where word 0 = bits 127:96.
  - Write `new_sboxw` back to that word.
- **MAIN**
  - ShiftRows, then MixColumns (omitted when round=10), then AddRoundKey, all in one cycle.
  - If round=10: `ciphertext` ← result, go to IDLE.
  - Otherwise: round+1, go to KEYGEN.
- MixColumns uses GF(2^8) xtime with reduction polynomial 0x11b. All arithmetic is bitwise XOR; no carries.
- Boundary rules:
  - `key`/`plaintext` changes after capture have no effect.
  - `init` while busy is ignored.
  - `init` held high in IDLE restarts immediately after completion.
- `ciphertext` holds its previous value until round 10 completes, and is never partially updated.

## Timing
- Reset values: `ready`=1, `ciphertext`=0, `sboxw`=0, FSM=IDLE, round=0.
- Reset mid-operation aborts at once to the reset values.
- `init` is sampled at edge T0. `ready` falls at T0 and rises again at T0+61: 1 INIT + 10×(1 KEYGEN + 4 SUB + 1 MAIN).
- `ciphertext` is valid in the same cycle `ready` rises.
- Critical path: `sboxw` → external S-box → `new_sboxw` → register, within one cycle.

## Configuration
- `AES_ENCIPHER_INTERNAL_SBOX_EN`
  - Defined: the core instantiates its own `aes_sbox` (4 bytes), ignores `new_sboxw`, and drives `sboxw` to 0.
  - Undefined: the external S-box port is used as specified.
- Cycle timing is identical in both builds.

## Structure
- Shared package `aes_pkg` holds:
  - state enum;
  - Rcon constants;
  - the xtime/MixColumns and ShiftRows functions, shared with the decipher core;
  - the forward S-box table.
- One sub-module: `aes_sbox`, a 32-bit word in/out forward lookup. It is used only under the macro, and mirrors the port shape of `aes_inv_sbox`.

## Test plan
- **FIPS-197 C.1:** key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a; `ready` low exactly 61 cycles.
- **FIPS-197 B:** key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32.
- **All-zero** key and pt → 66e94bd4ef8a2c3b884cfa59ca342b2e.
- **Init while busy / input changes:**
  - Pulse `init` and change `plaintext`/`key` at cycle 20 of an operation.
  - Result is still the originally captured vector; completion still at cycle 61.
- **Reset mid-operation:**
  - Assert `reset` at cycle 30: `ready`=1 and `ciphertext`=0 immediately (asynchronously).
  - A following C.1 run gives the correct result.
- **Back-to-back:** run C.1 then B without reset; `ciphertext` holds the C.1 value until the B completion edge.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES package: FSM state enum, Rcon, forward S-box table and the
// ShiftRows / MixColumns helpers used by the encipher and decipher cores.
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ROUND_W = 4;
  localparam int unsigned IDX_W   = 2;

  localparam logic [ROUND_W-1:0] LAST_ROUND = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_KEYGEN,
    ST_SUB,
    ST_MAIN
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant for rounds 1..10
  function automatic logic [7:0] get_rcon(input logic [ROUND_W-1:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Byte-wise forward substitution of one word
  function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Multiply by x in GF(2^8), polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column {a0,a1,a2,a3}
  function automatic logic [WORD_W-1:0] mix_column(input logic [WORD_W-1:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]), mix_column(s[31:0])};
  endfunction

  // Row r rotates left by r columns; byte (r,c) lives at index r+4c
  function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box on a 32-bit word (four parallel byte lookups).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] sboxw,
  output logic [WORD_W-1:0] new_sboxw
);

  assign new_sboxw = sub_word(sboxw);

endmodule

// File: rtl/aes_encipher_core.sv
// Iterative AES-128 encipher core with on-the-fly key expansion.
// Build option: define AES_ENCIPHER_INTERNAL_SBOX_EN to use a private
// aes_sbox instead of the external sboxw/new_sboxw port pair.
module aes_encipher_core
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [BLOCK_W-1:0] key,
  input  logic [BLOCK_W-1:0] plaintext,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic [WORD_W-1:0]  sboxw,
  input  logic [WORD_W-1:0]  new_sboxw,
  output logic               ready
);

  aes_state_e         r_state;
  logic [ROUND_W-1:0] r_round;
  logic [IDX_W-1:0]   r_idx;
  logic [BLOCK_W-1:0] r_block;
  logic [BLOCK_W-1:0] r_rkey;
  logic [BLOCK_W-1:0] r_ct;
  logic               r_ready;

  logic [WORD_W-1:0]  w_sbox_in;
  logic [WORD_W-1:0]  w_sbox_out;
  logic [WORD_W-1:0]  w_sub_word;
  logic [WORD_W-1:0]  w_nk0, w_nk1, w_nk2, w_nk3;
  logic [BLOCK_W-1:0] w_sr;
  logic [BLOCK_W-1:0] w_mc;
  logic [BLOCK_W-1:0] w_main;

  // Select the state word for SubBytes
  always_comb begin
    w_sub_word = r_block[127:96];
    case (r_idx)
      2'd0: w_sub_word = r_block[127:96];
      2'd1: w_sub_word = r_block[95:64];
      2'd2: w_sub_word = r_block[63:32];
      2'd3: w_sub_word = r_block[31:0];
      default: w_sub_word = r_block[127:96];
    endcase
  end

  // S-box request: RotWord(w3) during KEYGEN, state word during SUB
  always_comb begin
    w_sbox_in = '0;
    case (r_state)
      ST_KEYGEN: w_sbox_in = {r_rkey[23:0], r_rkey[31:24]};
      ST_SUB:    w_sbox_in = w_sub_word;
      default:   w_sbox_in = '0;
    endcase
  end

`ifdef AES_ENCIPHER_INTERNAL_SBOX_EN
  logic w_unused_new_sboxw;
  assign w_unused_new_sboxw = ^new_sboxw;
  assign sboxw = '0;
  aes_sbox u_sbox (
    .sboxw     (w_sbox_in),
    .new_sboxw (w_sbox_out)
  );
`else
  assign sboxw      = w_sbox_in;
  assign w_sbox_out = new_sboxw;
`endif

  // Next round key from the current one
  assign w_nk0 = r_rkey[127:96] ^ w_sbox_out ^ {get_rcon(r_round), 24'h0};
  assign w_nk1 = r_rkey[95:64] ^ w_nk0;
  assign w_nk2 = r_rkey[63:32] ^ w_nk1;
  assign w_nk3 = r_rkey[31:0]  ^ w_nk2;

  // ShiftRows, MixColumns (skipped in the final round), AddRoundKey
  assign w_sr   = shift_rows(r_block);
  assign w_mc   = (r_round == LAST_ROUND) ? w_sr : mix_columns(w_sr);
  assign w_main = w_mc ^ r_rkey;

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_round <= '0;
      r_idx   <= '0;
      r_block <= '0;
      r_rkey  <= '0;
      r_ct    <= '0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (init) begin
            r_block <= plaintext;
            r_rkey  <= key;
            r_ready <= 1'b0;
            r_state <= ST_INIT;
          end
        end
        ST_INIT: begin
          r_block <= r_block ^ r_rkey;
          r_round <= 4'd1;
          r_state <= ST_KEYGEN;
        end
        ST_KEYGEN: begin
          r_rkey  <= {w_nk0, w_nk1, w_nk2, w_nk3};
          r_idx   <= '0;
          r_state <= ST_SUB;
        end
        ST_SUB: begin
          case (r_idx)
            2'd0: r_block[127:96] <= w_sbox_out;
            2'd1: r_block[95:64]  <= w_sbox_out;
            2'd2: r_block[63:32]  <= w_sbox_out;
            2'd3: r_block[31:0]   <= w_sbox_out;
            default: r_block[127:96] <= w_sbox_out;
          endcase
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_state <= ST_MAIN;
          end
        end
        ST_MAIN: begin
          r_block <= w_main;
          if (r_round == LAST_ROUND) begin
            r_ct    <= w_main;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_round <= r_round + 4'd1;
            r_state <= ST_KEYGEN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ciphertext = r_ct;
  assign ready      = r_ready;

endmodule

// File: tb/tb_aes_encipher_core.sv
// Directed bench for aes_encipher_core with an expected-ciphertext scoreboard.
module tb_aes_encipher_core;
  import aes_pkg::*;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk;
  logic         reset;
  logic         init;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic [127:0] ciphertext;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic         ready;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  aes_encipher_core dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .key        (key),
    .plaintext  (plaintext),
    .ciphertext (ciphertext),
    .sboxw      (sboxw),
    .new_sboxw  (new_sboxw),
    .ready      (ready)
  );

  aes_sbox u_ext_sbox (
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one init pulse and record the expected result
  task automatic start_op(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e);
    @(negedge clk);
    key       = k;
    plaintext = p;
    init      = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    init = 1'b0;
    check("ready_fall", {127'b0, ready}, 128'd1 - 128'd1);
  endtask

  // Count busy cycles; optionally perturb inputs at a cycle and check ciphertext holds
  task automatic wait_done(input int perturb_at, input bit hold_en,
                           input logic [127:0] hold_val, output int n);
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      if (hold_en) check("ct_hold", ciphertext, hold_val);
      if (n == perturb_at) begin
        init      = 1'b1;
        key       = ~key;
        plaintext = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      if (n == perturb_at) init = 1'b0;
      n++;
    end
  endtask

  task automatic check_result(input string tag);
    logic [127:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 128'd1, 128'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, ciphertext, e);
    end
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    init      = 1'b0;
    key       = '0;
    plaintext = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {127'b0, ready}, 128'd1);
    check("rst_ct", ciphertext, 128'd0);
    check("rst_sboxw", {96'b0, sboxw}, 128'd0);
    reset = 1'b0;

    // FIPS-197 C.1
    start_op(KEY_C1, PT_C1, CT_C1);
    wait_done(-1, 1'b1, 128'd0, n);
    check("c1_latency", 128'(n), 128'd61);
    check_result("c1_ct");
    @(negedge clk);
    check("idle_sboxw", {96'b0, sboxw}, 128'd0);

    // Back-to-back FIPS-197 B; C.1 result must hold until completion
    start_op(KEY_B, PT_B, CT_B);
    wait_done(-1, 1'b1, CT_C1, n);
    check("b_latency", 128'(n), 128'd61);
    check_result("b_ct");

    // All-zero key and plaintext
    start_op(128'd0, 128'd0, CT_Z);
    wait_done(-1, 1'b0, 128'd0, n);
    check("z_latency", 128'(n), 128'd61);
    check_result("z_ct");

    // init and input changes while busy are ignored
    start_op(KEY_C1, PT_C1, CT_C1);
    wait_done(20, 1'b1, CT_Z, n);
    check("busy_latency", 128'(n), 128'd61);
    check_result("busy_ct");
    @(negedge clk);
    check("busy_no_restart", {127'b0, ready}, 128'd1);

    // Reset in the middle of an operation
    start_op(KEY_B, PT_B, CT_B);
    repeat (29) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_ready", {127'b0, ready}, 128'd1);
    check("midrst_ct", ciphertext, 128'd0);
    check("midrst_sboxw", {96'b0, sboxw}, 128'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    reset = 1'b0;
    start_op(KEY_C1, PT_C1, CT_C1);
    wait_done(-1, 1'b1, 128'd0, n);
    check("post_rst_latency", 128'(n), 128'd61);
    check_result("post_rst_ct");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
